// File: rtl/spi_buf_pkg.sv
// spi_buf_pkg: shared types and helpers for the SPI receive-buffer arbiter.
package spi_buf_pkg;
  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} arb_state_e;
  localparam int DefAddrBits = 12;
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational round-robin picker, first request at or after ptr_i.
module spi_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o = N'(1) << ((int'(ptr_i) + k) % N);
        idx_o = IW'((int'(ptr_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/spi_buf_arbiter.sv
// spi_buf_arbiter: shares the SPI receive buffer between SPI writes and host requesters.
// Define ARB_STARVE_EN to let starving requesters break a burst lock.
module spi_buf_arbiter
  import spi_buf_pkg::*;
#(
  parameter int AddrBits    = DefAddrBits,
  parameter int NumReq      = 2,
  parameter int StarveLimit = 15
) (
  input  logic                       SysClk,
  input  logic                       Reset_n,
  input  logic [AddrBits-1:0]        spiAddr,
  input  logic [7:0]                 spiData,
  input  logic                       spiWE,
  input  logic [NumReq-1:0]          reqValid,
  input  logic [NumReq-1:0]          reqWE,
  input  logic [NumReq-1:0]          reqLock,
  input  logic [NumReq*AddrBits-1:0] reqAddr,
  input  logic [NumReq*8-1:0]        reqWData,
  output logic [NumReq-1:0]          reqGrant,
  output logic [NumReq-1:0]          rspValid,
  output logic [7:0]                 rspData,
  output logic                       memEn,
  output logic                       memWE,
  output logic [AddrBits-1:0]        memAddr,
  output logic [7:0]                 memWData,
  input  logic [7:0]                 memRData
);
  localparam int IW = id_width(NumReq);
  arb_state_e state_q;
  logic [IW-1:0] ptr_q, owner_q, win, rd_id1_q, rd_id2_q;
  logic [NumReq-1:0] pick_req, pick_gnt;
  logic [1:0] rd_v_q;
  logic mem_en_q, mem_we_q, host_gnt, starve;
  logic [AddrBits-1:0] mem_addr_q;
  logic [7:0] mem_wdata_q;
  assign pick_req = (state_q == LOCKED) ? reqValid & (NumReq'(1) << owner_q) : reqValid;
  spi_rr_pick #(.N(NumReq), .IW(IW)) u_pick (
    .req_i(pick_req),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(win)
  );
  assign reqGrant = spiWE ? '0 : pick_gnt;
  assign host_gnt = ~spiWE & |pick_gnt;
  assign rspValid = rd_v_q[1] ? NumReq'(1) << rd_id2_q : '0;
  assign rspData  = memRData;
  assign memEn    = mem_en_q;
  assign memWE    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memWData = mem_wdata_q;
`ifdef ARB_STARVE_EN
  localparam int CW = $clog2(StarveLimit + 1);
  logic [CW-1:0] wait_q [NumReq];
  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NumReq; i++) wait_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++)
        wait_q[i] <= (!reqValid[i] || reqGrant[i]) ? '0 :
                     (wait_q[i] == CW'(StarveLimit)) ? wait_q[i] : wait_q[i] + 1'b1;
    end
  end
  always_comb begin
    starve = 1'b0;
    for (int i = 0; i < NumReq; i++)
      if (IW'(i) != owner_q && wait_q[i] == CW'(StarveLimit)) starve = 1'b1;
  end
`else
  assign starve = 1'b0;
`endif
  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ARB;
      owner_q     <= '0;
      ptr_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_v_q      <= '0;
      rd_id1_q    <= '0;
      rd_id2_q    <= '0;
    end else begin
      mem_en_q <= spiWE | host_gnt;
      mem_we_q <= spiWE | (host_gnt & reqWE[win]);
      if (spiWE) begin
        mem_addr_q  <= spiAddr;
        mem_wdata_q <= spiData;
      end else if (host_gnt) begin
        mem_addr_q  <= reqAddr[int'(win)*AddrBits +: AddrBits];
        mem_wdata_q <= reqWData[int'(win)*8 +: 8];
      end
      // id follows the valid bit so rspValid lines up with memRData two cycles later
      rd_v_q   <= {rd_v_q[0], host_gnt & ~reqWE[win]};
      rd_id1_q <= win;
      rd_id2_q <= rd_id1_q;
      if (host_gnt) ptr_q <= (win == IW'(NumReq - 1)) ? '0 : win + 1'b1;
      if (state_q == ARB) begin
        if (host_gnt && reqLock[win]) begin
          state_q <= LOCKED;
          owner_q <= win;
        end
      end else if (!reqLock[owner_q] || starve) begin
        state_q <= ARB;
      end
    end
  end
endmodule
